// File: rtl/pool_pkg.sv
// Shared float16 constants and the raw-bit-pattern max used by the pooling stage.
// No arithmetic is involved; the result is always one of the two operands.
package pool_pkg;

  localparam int FP16_W        = 16;
  localparam int FP16_SIGN_BIT = 15;
  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

  // NaN/Inf are ordered purely by their bit patterns, like any other value.
  function automatic logic [FP16_W-1:0] fp16_max(input logic [FP16_W-1:0] a,
                                                 input logic [FP16_W-1:0] b);
    logic [FP16_W-1:0] res;
    res = a;
    if (a[FP16_SIGN_BIT] != b[FP16_SIGN_BIT]) begin
      res = a[FP16_SIGN_BIT] ? b : a;
    end else if (!a[FP16_SIGN_BIT]) begin
      if (b[FP16_SIGN_BIT-1:0] > a[FP16_SIGN_BIT-1:0]) res = b;
    end else begin
      if (b[FP16_SIGN_BIT-1:0] < a[FP16_SIGN_BIT-1:0]) res = b;
    end
    return res;
  endfunction

endpackage

// File: rtl/fp16_max2.sv
// Combinational two-input float16 max; zero latency, no flow control.
module fp16_max2
  import pool_pkg::*;
(
  input  logic [FP16_W-1:0] a,
  input  logic [FP16_W-1:0] b,
  output logic [FP16_W-1:0] y
);

  assign y = fp16_max(a, b);

endmodule

// File: rtl/relu_maxpool2x2_stream.sv
// 2x2 stride-2 max pool over a row-major float16 stream, one cycle latency, no backpressure.
// Define RELU_POOL_RELU_EN to clamp negative pooled results (including -0) to +0.
module relu_maxpool2x2_stream
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 26,
  parameter int IMG_H      = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iValid,
  input  logic [DATA_WIDTH-1:0] iData,
  output logic                  oValid,
  output logic [DATA_WIDTH-1:0] oData,
  output logic                  oFrameDone
);

  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int HALF_W = IMG_W / 2;
  localparam int HALF_H = IMG_H / 2;
  localparam int LW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_POOL_LAST = CW'(2 * HALF_W - 1);
  localparam logic [RW-1:0] ROW_POOL_LAST = RW'(2 * HALF_H - 1);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [FP16_W-1:0]     pair_reg;
  logic [FP16_W-1:0]     pair_max;
  logic [FP16_W-1:0]     win_max;
  logic [FP16_W-1:0]     pool_out;
  logic [FP16_W-1:0]     lb_rd;
  logic [LW-1:0]         lb_idx;
  logic [FP16_W-1:0]     line_buf [HALF_W];
  logic                  in_pool;
  logic                  lb_wr;
  logic                  win_fire;
  logic                  last_win;

  // Odd trailing column/row fall outside the pooled area and are skipped.
  assign in_pool  = (col <= COL_POOL_LAST) && (row <= ROW_POOL_LAST);
  assign lb_wr    = iValid && col[0] && !row[0] && in_pool;
  assign win_fire = iValid && col[0] && row[0] && in_pool;
  assign last_win = (col == COL_POOL_LAST) && (row == ROW_POOL_LAST);
  assign lb_idx   = LW'(col >> 1);
  assign lb_rd    = line_buf[lb_idx];

  fp16_max2 u_pair_max (
    .a (pair_reg),
    .b (iData),
    .y (pair_max)
  );

  fp16_max2 u_win_max (
    .a (lb_rd),
    .b (pair_max),
    .y (win_max)
  );

`ifdef RELU_POOL_RELU_EN
  assign pool_out = win_max[FP16_SIGN_BIT] ? FP16_ZERO : win_max;
`else
  assign pool_out = win_max;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (iValid) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_reg <= FP16_ZERO;
    end else if (iValid && !col[0]) begin
      pair_reg <= iData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HALF_W; i++) line_buf[i] <= FP16_ZERO;
    end else if (lb_wr) begin
      line_buf[lb_idx] <= pair_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oValid     <= 1'b0;
      oData      <= '0;
      oFrameDone <= 1'b0;
    end else begin
      oValid     <= win_fire;
      oFrameDone <= win_fire && last_win;
      if (win_fire) oData <= pool_out;
    end
  end

endmodule

// File: doc/relu_maxpool2x2_stream.md
Name: relu_maxpool2x2_stream

Overview:
- Downstream neighbour of the 3-channel float16 conv unit: consumes its serial result/oValid stream, one float16 per valid cycle, row-major, IMG_W x IMG_H feature map.
- Performs 2x2 stride-2 max pooling, with optional ReLU, and emits one pooled float16 per 2x2 window.
- Feeds the next conv layer's input stream; no backpressure anywhere in the chain.

Parameters:
- DATA_WIDTH, 16, float16 word width (1 sign, 5 exp, 10 mantissa)
- IMG_W, 26, input feature-map width in pixels (>=2)
- IMG_H, 26, input feature-map height in pixels (>=2)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- iValid  input  1  input pixel valid (driven by conv unit oValid)
- iData  input  DATA_WIDTH  input pixel, float16
- oValid  output  1  pooled result valid, single-cycle pulse per window
- oData  output  DATA_WIDTH  pooled float16 result
- oFrameDone  output  1  one-cycle pulse, coincident with the last pooled output of a frame

Behaviour:
- Reset (async, rst_n=0): col, row, pair register, line buffer valid state cleared; oValid=0, oData=0, oFrameDone=0. Reset mid-frame discards the partial frame; the next iValid is pixel (0,0).
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 advance only on iValid. col wraps to 0 at IMG_W-1 and increments row; row wraps to 0 after (IMG_W-1, IMG_H-1). Gaps in iValid are allowed; state holds.
- Pair stage: on even col, latch iData into pair_reg. On odd col, pair_max = max(pair_reg, iData).
- Even row, odd col: write pair_max to line_buf[col>>1]. Depth is IMG_W/2 entries, DATA_WIDTH each.
- Odd row, odd col: win_max = max(line_buf[col>>1], pair_max). Register it to oData with oValid=1 on the next clock (latency 1 cycle after the iValid that completes the window).
- Odd IMG_W: last column ignored. Odd IMG_H: last row ignored; no writes, no outputs.
- Outputs per frame: (IMG_W/2)*(IMG_H/2). oFrameDone asserts with the final one.
- oData holds its last value when oValid=0.
- float16 max, combinational, on raw bit patterns:
  - Signs differ: the non-negative operand wins.
  - Both positive: larger magnitude [14:0] wins.
  - Both negative: smaller magnitude wins.
  - Equal: either (bitwise first operand).
  - +0 vs -0: +0 wins.
  - NaN/Inf are not special-cased; they follow the bit rules above.
- No arithmetic is performed, so no rounding occurs. Output is always one of the input words, or 0 under RELU.

Optional Feature:
- Macro RELU_POOL_RELU_EN.
- Defined: the registered output is ReLU(win_max). Any word with sign=1 (including -0) becomes 16'h0000. Latency is unchanged.
- Undefined: the raw max is output; negative values pass through.

Decomposition:
- Shared package pool_pkg holds:
  - FP16_W=16, FP16_SIGN_BIT=15, FP16_ZERO=16'h0000
  - function fp16_max(a,b) implementing the compare rules above
- One natural sub-module: fp16_max2 (combinational two-input float16 max, wraps fp16_max). Instantiated twice: pair stage and window stage.
- Line buffer is an inferred register/RAM array inside the top; it is not a separate module.

Test Plan:
- IMG_W=4, IMG_H=2, continuous iValid, rows {1.0,2.0,3.0,4.0} / {5.0,0.5,0.25,6.0} (3C00,4000,4200,4400 / 4500,3800,3400,4600) -> exactly two oValid pulses: 4500 then 4600, one cycle after the 6th and 8th inputs. oFrameDone asserts with 4600.
- Mixed signs, window {-2.0,-1.0,-3.0,-0.5} (C000,BC00,C200,B800) -> without RELU output B800. With RELU_POOL_RELU_EN output 0000.
- Zero signs, window {8000,0000,8000,8000} -> output 0000.
- Bubbles: same data as the first case with iValid deasserted every other cycle -> identical outputs and order; oValid only follows a completing valid beat.
- Odd size IMG_W=5, IMG_H=3, 15 pixels -> exactly two outputs per frame. Column 4 and row 2 never appear. Counters wrap, and a second frame repeats identically.
- Reset mid-frame: assert rst_n=0 after 5 pixels of the 4x2 frame -> oValid=0 immediately. A full fresh frame afterwards gives the same outputs as the first case.
